// File: rtl/counter8_capture_fifo.sv
// Timestamp capture: samples the free-running counter on each rising edge of
// event_in and queues it in a small first-word-fall-through FIFO with sticky overflow.
module counter8_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           count,
  input  logic                       event_in,
  input  logic                       rd_en,
  input  logic                       clr_ovf,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0]    LVL_ONE = LW'(1);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [WIDTH-1:0] ZERO_D  = '0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_next_s;
  logic             overflow_r;
  logic             event_d;
  logic             cap_s;
  logic             do_rd_s;
  logic             do_wr_s;
  logic             drop_s;

  // Request and accept decisions; a full FIFO still accepts when a pop frees a slot.
  always_comb begin
    cap_s   = event_in & ~event_d;
    do_rd_s = rd_en & ~empty;
    do_wr_s = cap_s & (~full | rd_en);
    drop_s  = cap_s & full & ~rd_en;
  end

  // Occupancy update from the accepted push/pop pair.
  always_comb begin
    level_next_s = level_r;
    if (do_wr_s && !do_rd_s) begin
      level_next_s = level_r + LVL_ONE;
    end else if (do_rd_s && !do_wr_s) begin
      level_next_s = level_r - LVL_ONE;
    end else begin
      level_next_s = level_r;
    end
  end

  // Pointers, level, overflow and edge-detect history; event_d resets high so a
  // level held through reset release does not count as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      overflow_r <= 1'b0;
      event_d    <= 1'b1;
    end else begin
      event_d <= event_in;
      level_r <= level_next_s;
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem[wr_ptr_r] <= count;
    end
  end

  // Status and head-of-queue view.
  always_comb begin
    empty    = (level_r == '0);
    full     = (level_r == DEPTH_L);
    level    = level_r;
    overflow = overflow_r;
    if (empty) begin
      rd_data = ZERO_D;
    end else begin
      rd_data = mem[rd_ptr_r];
    end
  end

endmodule

// File: doc/counter8_capture_fifo.md
# counter8_capture_fifo

Timestamp-capture stage placed directly downstream of the 8-bit free-running counter. On each rising edge of an external event it samples the counter's current `result` value and pushes it into a small first-word-fall-through FIFO, which a consumer drains with a read strobe. Drops on a full FIFO are flagged by a sticky overflow bit, so software can tell captured timestamps from lost ones.

## Interface
Parameters:
- `WIDTH`, 8: capture width; matches the counter output.
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `count`  in  WIDTH  counter value, connected to the counter's `result`.
- `event_in`  in  1  event level, already synchronous to `clk`.
- `rd_en`  in  1  pop the head entry.
- `clr_ovf`  in  1  clear the sticky overflow flag.
- `rd_data`  out  WIDTH  head entry (first-word-fall-through); 0 when empty.
- `empty`  out  1  FIFO holds 0 entries.
- `full`  out  1  FIFO holds DEPTH entries.
- `level`  out  log2(DEPTH)+1  entry count, 0..DEPTH.
- `overflow`  out  1  sticky flag: a capture was dropped.

## Operation
- **Edge detect.** Internal register `event_d` <= `event_in`; reset value is 1.
  - A capture request occurs when `event_in`=1 and `event_d`=0.
  - Because `event_d` resets to 1, an `event_in` held high through reset release does not capture. `event_in` must first go low.
- **Capture.** The value of `count` present at the same clock edge as the capture request is written at the write pointer.
- **Write.**
  - Accepted if not full, or if full and `rd_en`=1 in the same cycle.
  - Otherwise the capture is dropped and `overflow` is set.
- **Read.**
  - `rd_en` while empty is ignored: no pointer change, no flag change.
  - `rd_en` while not empty advances the read pointer.
- **Simultaneous write and read.**
  - Not empty: both happen and `level` is unchanged.
  - Empty: only the write happens and `level` becomes 1.
- **Pointers and flags.**
  - Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - `level` is held in its own register.
  - `empty` = (`level`==0). `full` = (`level`==DEPTH).
- **Overflow flag.**
  - `clr_ovf` clears it on the next edge.
  - If a drop occurs in the same cycle as `clr_ovf`, set wins and `overflow` stays 1.
- **`rd_data`.** Combinational: mem[rd_ptr] when not empty, otherwise 0.
  - Storage array contents are not reset; only the pointers and flags are.
- **No wrap interpretation.** The block does not interpret counter wrap. Values are stored raw, e.g. 8'hFF followed by 8'h02 is legal.

## Timing
- **Reset state** (asynchronous, takes effect immediately):
  - `rd_data`=0, `empty`=1, `full`=0, `level`=0, `overflow`=0.
  - Pointers 0, `event_d`=1.
- **Capture latency.** For an edge detected at clock edge N: `empty` falls, `level` increments and `rd_data` shows the value after edge N. The data is readable in the cycle N..N+1.
- **Read latency.** `rd_en` sampled at edge M: the next entry (or 0 if now empty) appears on `rd_data` after edge M.
- **Throughput.**
  - At most one capture per two cycles, because an edge needs a low cycle in between.
  - One read per cycle.
- **Reset mid-operation.** All queued entries are discarded and flags return to their reset values. A capture pending on the same edge as reset assertion is lost.

## Test plan
- **Reset and basic capture.**
  - Stimulus: hold `reset` with `event_in`=1, release, keep `event_in`=1 for 5 cycles.
  - Required: `empty` stays 1, `level`=0. Then drop `event_in` low and raise it while `count`=8'h23: one cycle later `rd_data`=8'h23, `level`=1.
- **Fill, overflow and clear.**
  - Stimulus: 5 event edges at counts 10, 20, 30, 40, 50 with no reads.
  - Required:
    - `full`=1 and `level`=4 after the 4th edge.
    - `overflow`=1 after the 5th edge.
    - Reads return 10, 20, 30, 40, then `empty`=1 and `rd_data`=0.
    - Pulsing `clr_ovf` clears `overflow`.
- **Full plus simultaneous read and write.**
  - Stimulus: with the FIFO full of 1, 2, 3, 4, assert `rd_en` in the same cycle as a capture of 8'h99.
  - Required: `overflow` stays 0, `level` stays 4, and drained order is 2, 3, 4, 8'h99.
- **Empty read and same-cycle push.**
  - Stimulus: on an empty FIFO, pulse `rd_en` alone, then pulse `rd_en` together with a capture of 8'h07.
  - Required: the first pulse leaves `level`=0. After the second, `level`=1 and `rd_data`=8'h07.
- **Pointer wrap across counter wrap.**
  - Stimulus: perform 10 capture/read pairs while `count` runs through 8'hFE, 8'hFF, 8'h00.
  - Required: every value is read back in order, and `level` never exceeds 1.
- **Reset mid-operation and clear/drop collision.**
  - Stimulus: queue 3 entries, then assert `reset` asynchronously between clock edges. Separately, assert `clr_ovf` in the same cycle as a drop on a full FIFO.
  - Required: after the reset, `empty`=1 and `level`=0 immediately. In the collision case, `overflow` remains 1.
